// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the single memory port, fetch (A) vs load/store (B)
module mem_port_arbiter #(
  parameter int TIMEOUT  = 15,
  parameter int CNT_SIZE = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_A,
  input  logic WE_A,
  input  logic REQ_B,
  input  logic WE_B,
  input  logic MEM_READY,
  output logic SEL,
  output logic GNT_A,
  output logic GNT_B,
  output logic MEM_REQ,
  output logic MEM_WE,
  output logic DONE_A,
  output logic DONE_B,
  output logic ERR
);
  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;
  state_t state, state_n;
  logic [CNT_SIZE-1:0] cnt, cnt_n;
  logic last, last_n, sel_n, we_n, done_a_n, done_b_n, err_n;
  logic eff_a, eff_b, fin;
  assign eff_a = REQ_A && !DONE_A;
  assign eff_b = REQ_B && !DONE_B;
  assign fin = MEM_READY || cnt == CNT_SIZE'(TIMEOUT - 1);
  // next state: grant in IDLE with last-served tie-break, finish on ready or expiry
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last;
    sel_n = SEL;
    we_n = MEM_WE;
    done_a_n = 1'b0;
    done_b_n = 1'b0;
    err_n = 1'b0;
    if (state == IDLE) begin
      if (eff_a && (!eff_b || last)) begin
        state_n = BUSY_A;
        sel_n = 1'b0;
        we_n = WE_A;
        last_n = 1'b0;
        cnt_n = '0;
      end else if (eff_b) begin
        state_n = BUSY_B;
        sel_n = 1'b1;
        we_n = WE_B;
        last_n = 1'b1;
        cnt_n = '0;
      end
    end else if (fin) begin
      state_n = IDLE;
      we_n = 1'b0;
      cnt_n = '0;
      done_a_n = state == BUSY_A;
      done_b_n = state == BUSY_B;
      err_n = !MEM_READY;
    end else begin
      cnt_n = cnt + CNT_SIZE'(1);
    end
  end
  // state and registered outputs; reset abandons any access silently
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      last <= 1'b1;
      SEL <= 1'b0;
      GNT_A <= 1'b0;
      GNT_B <= 1'b0;
      MEM_REQ <= 1'b0;
      MEM_WE <= 1'b0;
      DONE_A <= 1'b0;
      DONE_B <= 1'b0;
      ERR <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
      SEL <= sel_n;
      GNT_A <= state_n == BUSY_A;
      GNT_B <= state_n == BUSY_B;
      MEM_REQ <= state_n != IDLE;
      MEM_WE <= we_n;
      DONE_A <= done_a_n;
      DONE_B <= done_b_n;
      ERR <= err_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench, output vector {SEL,GNT_A,GNT_B,MEM_REQ,MEM_WE,DONE_A,DONE_B,ERR}
module tb_mem_port_arbiter;
  logic CLK, RST, REQ_A, WE_A, REQ_B, WE_B, MEM_READY;
  logic SEL, GNT_A, GNT_B, MEM_REQ, MEM_WE, DONE_A, DONE_B, ERR;
  logic [7:0] obs, exp_v;
  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(.TIMEOUT(15), .CNT_SIZE(8)) dut (
    .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .WE_A(WE_A), .REQ_B(REQ_B), .WE_B(WE_B),
    .MEM_READY(MEM_READY), .SEL(SEL), .GNT_A(GNT_A), .GNT_B(GNT_B), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .DONE_A(DONE_A), .DONE_B(DONE_B), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    obs = {SEL, GNT_A, GNT_B, MEM_REQ, MEM_WE, DONE_A, DONE_B, ERR};
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; WE_B = 1'b1; MEM_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      tick();
      exp_v = exp_q.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset cyc%0d got %h want %h", i, obs, exp_v); end
    end
    RST = 1'b0; MEM_READY = 1'b0; WE_B = 1'b0;
    exp_q.push_back(8'h50);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL reset_first_grant got %h want %h", obs, exp_v); end
    MEM_READY = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0;
    exp_q.push_back(8'h04);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL reset_done_a got %h want %h", obs, exp_v); end
    MEM_READY = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL reset_idle got %h want %h", obs, exp_v); end
  endtask

  task automatic test_single_b_write();
    REQ_B = 1'b1; WE_B = 1'b1; MEM_READY = 1'b0;
    exp_q.push_back(8'hB8);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL b_write_grant got %h want %h", obs, exp_v); end
    for (int i = 0; i < 4; i++) begin
      MEM_READY = (i == 3);
      WE_B = (i == 0);
      REQ_B = (i < 2);
      exp_q.push_back(i == 3 ? 8'h82 : 8'hB8);
      tick();
      exp_v = exp_q.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL b_write cyc%0d got %h want %h", i + 1, obs, exp_v); end
    end
    MEM_READY = 1'b0;
    exp_q.push_back(8'h80);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL b_write_idle got %h want %h", obs, exp_v); end
  endtask

  task automatic test_round_robin();
    logic [7:0] e [10];
    logic r [10];
    e = '{8'h50, 8'h04, 8'hB0, 8'h82, 8'h50, 8'h04, 8'h00, 8'hB0, 8'h82, 8'h80};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    WE_A = 1'b0; WE_B = 1'b0; MEM_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      REQ_A = r[i]; REQ_B = r[i];
      exp_q.push_back(e[i]);
      tick();
      exp_v = exp_q.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL round_robin cyc%0d got %h want %h", i, obs, exp_v); end
      tests++;
      if ((GNT_A && GNT_B) || (MEM_REQ !== (GNT_A | GNT_B))) begin
        fails++; $display("FAIL rr_invariant cyc%0d got gnt_a=%b gnt_b=%b mem_req=%b", i, GNT_A, GNT_B, MEM_REQ);
      end
    end
    MEM_READY = 1'b0;
  endtask

  task automatic run_a_wait(input bit ready_last, input string name);
    REQ_A = 1'b1; REQ_B = 1'b0; WE_A = 1'b0; MEM_READY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      MEM_READY = ready_last && (i == 15);
      exp_q.push_back(i < 15 ? 8'h50 : (ready_last ? 8'h04 : 8'h05));
      tick();
      exp_v = exp_q.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL %s cyc%0d got %h want %h", name, i, obs, exp_v); end
    end
    REQ_A = 1'b0; MEM_READY = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL %s_idle got %h want %h", name, obs, exp_v); end
  endtask

  task automatic test_timeout();
    run_a_wait(1'b0, "timeout");
  endtask

  task automatic test_ready_on_timeout();
    run_a_wait(1'b1, "ready_on_timeout");
  endtask

  task automatic test_reset_mid_access();
    REQ_B = 1'b1; WE_B = 1'b0; MEM_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'hB0);
      tick();
      exp_v = exp_q.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL mid_busy cyc%0d got %h want %h", i, obs, exp_v); end
    end
    RST = 1'b1; REQ_A = 1'b1; MEM_READY = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL mid_reset got %h want %h", obs, exp_v); end
    RST = 1'b0; REQ_B = 1'b0; MEM_READY = 1'b0;
    exp_q.push_back(8'h50);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL mid_regrant_a got %h want %h", obs, exp_v); end
    MEM_READY = 1'b1;
    exp_q.push_back(8'h04);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL mid_done_a got %h want %h", obs, exp_v); end
    REQ_A = 1'b0; MEM_READY = 1'b0;
    exp_q.push_back(8'h00);
    tick();
    exp_v = exp_q.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL mid_idle got %h want %h", obs, exp_v); end
  endtask

  initial begin
    RST = 1'b1; REQ_A = 1'b0; WE_A = 1'b0; REQ_B = 1'b0; WE_B = 1'b0; MEM_READY = 1'b0;
    test_reset();
    test_single_b_write();
    test_round_robin();
    test_timeout();
    test_ready_on_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
